// File: rtl/pso_fitness.sv
// Fitness evaluation for the MPPT particle-swarm tracker: apply each particle's duty, settle,
// average 2^AVG_LOG2 V*I samples and emit a tagged fitness word. Optional macro: FIT_OVERCURRENT_EN.
module pso_fitness #(
    parameter int          AVG_LOG2   = 2,
    parameter int          SETTLE_CYC = 1000,
    parameter logic [11:0] I_LIMIT    = 12'hF00
) (
    input  logic        clk_P,
    input  logic        reset,
    input  logic        ena,
    input  logic        start,
    input  logic [9:0]  d0,
    input  logic [9:0]  d1,
    input  logic [9:0]  d2,
    input  logic [11:0] v_adc,
    input  logic [11:0] i_adc,
    input  logic        adc_valid,
    output logic [9:0]  duty_out,
    output logic [15:0] p_fit,
    output logic [1:0]  addr,
    output logic        busy,
    output logic        done
);

    localparam int          ACC_W       = 24 + AVG_LOG2;
    localparam int          NSAMP       = 1 << AVG_LOG2;
    localparam logic [4:0]  LAST_SAMP   = 5'(NSAMP - 1);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_SAMPLE,
        S_EMIT,
        S_FINISH
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [9:0]         r_d0;
    logic [9:0]         r_d1;
    logic [9:0]         r_d2;
    logic [1:0]         r_idx;
    logic [15:0]        r_settle;
    logic [4:0]         r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [9:0]         r_duty_out;
    logic [15:0]        r_p_fit;
    logic [1:0]         r_addr;
    logic               r_busy;
    logic               r_done;

    logic [23:0]        w_prod;
    logic [ACC_W-1:0]   w_acc_sum;
    logic               w_last_samp;
    logic [9:0]         w_duty_sel;
    logic [15:0]        w_fit;

    // Averaging divides by 2^AVG_LOG2 and keeps the top 16 bits of the 24-bit mean power.
    function automatic logic [15:0] fit_trunc(input logic [ACC_W-1:0] acc);
        return 16'(acc >> (AVG_LOG2 + 8));
    endfunction

    assign w_prod      = 24'(v_adc) * 24'(i_adc);
    assign w_acc_sum   = r_acc + ACC_W'(w_prod);
    assign w_last_samp = (r_state == S_SAMPLE) && adc_valid && (r_cnt == LAST_SAMP);

`ifdef FIT_OVERCURRENT_EN
    logic r_fault;
    logic w_fault_next;

    // The sample that completes the window can itself trip the fault.
    assign w_fault_next = r_fault | (i_adc > I_LIMIT);
    assign w_fit        = w_fault_next ? 16'h0000 : fit_trunc(w_acc_sum);
`else
    assign w_fit        = fit_trunc(w_acc_sum);
`endif

    always_comb begin
        w_duty_sel = r_d2;
        case (r_idx)
            2'd0:    w_duty_sel = r_d0;
            2'd1:    w_duty_sel = r_d1;
            default: w_duty_sel = r_d2;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_APPLY;
            S_APPLY:  w_next = S_SETTLE;
            S_SETTLE: if (r_settle == 16'd0) w_next = S_SAMPLE;
            S_SAMPLE: if (w_last_samp) w_next = S_EMIT;
            S_EMIT:   w_next = (r_idx < 2'd2) ? S_APPLY : S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_P) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_d0       <= '0;
            r_d1       <= '0;
            r_d2       <= '0;
            r_idx      <= '0;
            r_settle   <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_duty_out <= '0;
            r_p_fit    <= '0;
            r_addr     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef FIT_OVERCURRENT_EN
            r_fault    <= 1'b0;
`endif
        end else if (ena) begin
            r_state <= w_next;
            // addr/done/busy are registered from the next state so they line up with p_fit.
            r_addr  <= (w_next == S_EMIT) ? r_idx + 2'd1 : 2'd0;
            r_done  <= (w_next == S_FINISH);
            r_busy  <= (w_next == S_APPLY) || (w_next == S_SETTLE) ||
                       (w_next == S_SAMPLE) || (w_next == S_EMIT);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_d0  <= d0;
                        r_d1  <= d1;
                        r_d2  <= d2;
                        r_idx <= 2'd0;
                    end
                end
                S_APPLY: begin
                    r_duty_out <= w_duty_sel;
                    r_settle   <= SETTLE_LOAD;
                    r_acc      <= '0;
                    r_cnt      <= '0;
`ifdef FIT_OVERCURRENT_EN
                    r_fault    <= 1'b0;
`endif
                end
                S_SETTLE: begin
                    if (r_settle != 16'd0) begin
                        r_settle <= r_settle - 16'd1;
                    end else begin
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                S_SAMPLE: begin
                    if (adc_valid) begin
                        r_acc <= w_acc_sum;
                        r_cnt <= r_cnt + 5'd1;
`ifdef FIT_OVERCURRENT_EN
                        r_fault <= w_fault_next;
`endif
                        if (w_last_samp) r_p_fit <= w_fit;
                    end
                end
                S_EMIT: begin
                    if (r_idx < 2'd2) r_idx <= r_idx + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign duty_out = r_duty_out;
    assign p_fit    = r_p_fit;
    assign addr     = r_addr;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
